// File: rtl/color_arbiter.sv
// color_arbiter: round-robin N-way arbiter for t_color beats, registered output.
// Optional ARB/LOCK burst lock is enabled by defining COLOR_ARB_LOCK_EN.
package color_arbiter_pkg;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } t_color;
endpackage

module color_arbiter
    import color_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_vld,
    output logic [N-1:0]   in_rdy,
    input  t_color [N-1:0] in_color,
    input  logic [N-1:0]   in_last,
    output logic           out_vld,
    input  logic           out_rdy,
    output t_color         out_color,
    output logic [IW-1:0]  out_id,
    output logic           out_last
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] grant_rr;
    logic [IW-1:0] grant;
    logic          found;
    logic          gnt_vld;
    logic          load;
    logic          accept;
    logic          locked;
    logic          last_sel;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // Search upward from ptr with explicit wrap so non-power-of-2 N works
    always_comb begin
        grant_rr = ptr;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            int            j;
            logic [IW-1:0] idx;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            idx = IW'(j);
            if (!found && in_vld[idx]) begin
                found    = 1'b1;
                grant_rr = idx;
            end
        end
    end

`ifdef COLOR_ARB_LOCK_EN
    typedef enum logic {ARB, LOCK} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] lock_id;
    logic [IW-1:0] lock_id_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lock_id_nxt = lock_id;
        unique case (state)
            ARB: begin
                if (accept && !last_sel) begin
                    state_nxt   = LOCK;
                    lock_id_nxt = grant;
                end
            end
            LOCK: begin
                if (accept && last_sel) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // A valid drop from the lock owner stalls rather than releasing the lock
    assign locked   = (state == LOCK);
    assign grant    = locked ? lock_id : grant_rr;
    assign gnt_vld  = locked ? in_vld[lock_id] : found;
    assign last_sel = in_last[grant];
`else
    wire unused_last = ^in_last;

    assign locked   = 1'b0;
    assign grant    = grant_rr;
    assign gnt_vld  = found;
    assign last_sel = 1'b0;
`endif

    assign load   = !out_vld || out_rdy;
    assign accept = load && gnt_vld;

    always_comb begin
        in_rdy = '0;
        if (accept) in_rdy[grant] = 1'b1;
    end

    always_comb begin
        ptr_nxt = ptr;
        if (accept && (!locked || last_sel)) ptr_nxt = wrap_inc(grant);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld   <= 1'b0;
            out_color <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_vld <= accept;
            if (accept) begin
                out_color <= in_color[grant];
                out_id    <= grant;
                out_last  <= last_sel;
            end
        end
    end

endmodule

// File: tb/tb_color_arbiter.sv
// tb_color_arbiter: table vectors, burst/lock sequence and random traffic
// checked against a cycle-level behavioural model of the arbiter.
module tb_color_arbiter;
    import color_arbiter_pkg::*;

    localparam int N = 4;
`ifdef COLOR_ARB_LOCK_EN
    localparam bit LOCKMODE = 1'b1;
`else
    localparam bit LOCKMODE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_vld;
    logic [N-1:0]   in_rdy;
    t_color [N-1:0] in_color;
    logic [N-1:0]   in_last;
    logic           out_vld;
    logic           out_rdy;
    t_color         out_color;
    logic [1:0]     out_id;
    logic           out_last;

    color_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_color(in_color), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_color(out_color), .out_id(out_id),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] last_rdy = '0;

    // model state
    bit          m_vld;
    logic [23:0] m_color;
    int          m_id;
    bit          m_last;
    int          m_ptr;
    bit          m_lock;
    int          m_lock_id;

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        int         id;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_vld = 0; m_color = '0; m_id = 0; m_last = 0;
        m_ptr = 0; m_lock = 0; m_lock_id = 0;
    endtask

    task automatic set_colors();
        for (int i = 0; i < N; i++) in_color[i] = {3{8'(i)}};
    endtask

    // One clock: check in_rdy mid-cycle, advance model, check outputs after edge
    task automatic cycle();
        bit          any;
        bit          ld;
        int          g;
        logic [3:0]  er;
        logic [23:0] pc;
        bit          pl;
        @(negedge clk);
        ld  = !m_vld || out_rdy;
        any = 0;
        g   = 0;
        if (m_lock) begin
            g   = m_lock_id;
            any = in_vld[g[1:0]];
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!any && in_vld[j[1:0]]) begin
                    any = 1;
                    g   = j;
                end
            end
        end
        er = (ld && any) ? 4'(1 << g) : 4'b0;
        last_rdy = in_rdy;
        chk("in_rdy", 32'(in_rdy), 32'(er));
        pc = in_color[g[1:0]];
        pl = LOCKMODE && in_last[g[1:0]];
        @(posedge clk);
        if (ld) begin
            if (any) begin
                m_vld = 1; m_color = pc; m_id = g; m_last = pl;
                if (!m_lock) begin
                    m_ptr = (g + 1) % N;
                    if (LOCKMODE && !pl) begin
                        m_lock = 1;
                        m_lock_id = g;
                    end
                end else if (pl) begin
                    m_lock = 0;
                    m_ptr = (g + 1) % N;
                end
            end else begin
                m_vld = 0;
            end
        end
        #1;
        chk("out_vld", 32'(out_vld), 32'(m_vld));
        chk("out_color", 32'(out_color), 32'(m_color));
        chk("out_id", 32'(out_id), 32'(m_id));
        chk("out_last", 32'(out_last), 32'(m_last));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ids[$];
        int lasts[$];
        int exp_ids[4];
        int exp_lasts[4];
        int b;

        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
        tbl[1]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3};
        tbl[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
        tbl[4]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
        tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
        tbl[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
        tbl[12] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
        tbl[13] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 3};
        tbl[14] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 3};
        tbl[15] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 3};
        tbl[16] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
        tbl[17] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1};
        tbl[19] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2};
        tbl[20] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2};
        tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2};

        if (LOCKMODE) begin
            exp_ids   = '{1, 1, 1, 0};
            exp_lasts = '{0, 0, 1, 1};
        end else begin
            exp_ids   = '{1, 0, 1, 0};
            exp_lasts = '{0, 0, 0, 0};
        end

        rst = 1'b1;
        in_vld = '0; in_last = '0; out_rdy = 1'b0;
        set_colors();
        #2 rst = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_color", 32'(out_color), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        // traffic, then reset mid-stream with a beat held in the output
        in_vld = 4'hF; in_last = 4'hF; out_rdy = 1'b1;
        repeat (3) cycle();
        in_vld = '0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_out_color", 32'(out_color), 32'd0);
        chk("mid_rst_out_id", 32'(out_id), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b1;

        for (int r = 0; r < 22; r++) begin
            in_vld  = tbl[r].vld;
            out_rdy = tbl[r].ordy;
            cycle();
            chk("tbl_rdy", 32'(last_rdy), 32'(tbl[r].rdy));
            chk("tbl_vld", 32'(out_vld), 32'(tbl[r].ov));
            chk("tbl_id", 32'(out_id), 32'(tbl[r].id));
            chk("tbl_color", 32'(out_color), 32'({3{8'(tbl[r].id)}}));
        end

        // source 0 alone moves ptr to 1, then source 1 bursts 3 beats with a gap
        in_vld = 4'b0001; out_rdy = 1'b1;
        cycle();
        b = 3;
        for (int c = 0; c < 6; c++) begin
            in_vld[0]   = 1'b1;
            in_last[0]  = 1'b1;
            in_vld[1]   = (b > 0) && (c != 1);
            in_last[1]  = (b == 1);
            in_color[1] = 24'h100000 + 24'(b);
            cycle();
            if (c == 1)
                chk("gap_rdy", 32'(last_rdy), LOCKMODE ? 32'd0 : 32'd1);
            if (last_rdy[1]) b--;
            if (out_vld) begin
                ids.push_back(int'(out_id));
                lasts.push_back(int'(out_last));
            end
        end
        if (ids.size() < 4) begin
            checks++;
            errors++;
            $display("FAIL burst_count: got %0d beats required 4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("burst_id", 32'(ids[k]), 32'(exp_ids[k]));
                chk("burst_last", 32'(lasts[k]), 32'(exp_lasts[k]));
            end
        end

        // random traffic with sources that hold until accepted
        in_vld = '0; in_last = '0;
        last_rdy = '0;
        for (int c = 0; c < 400; c++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (in_vld[i] && last_rdy[i]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        in_color[i] = 24'($urandom);
                        in_last[i]  = ($urandom_range(0, 2) != 0);
                    end else begin
                        in_vld[i] = 1'b0;
                    end
                end else if (!in_vld[i] && $urandom_range(0, 9) < 4) begin
                    in_vld[i]   = 1'b1;
                    in_color[i] = 24'($urandom);
                    in_last[i]  = ($urandom_range(0, 2) != 0);
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
